// File: rtl/sinus_nco.sv
// Phase-accumulator sine NCO: accumulator -> sampled index/amplitude -> sine ROM read -> scale.
// Three register stages after the accumulator, with the enable carried alongside as out_valid.
module sinus_nco #(
  parameter int ACC_BITS   = 24,
  parameter int PHASE_BITS = 5,
  parameter int AMP_BITS   = 6,
  parameter int OUT_BITS   = 8
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       en,
  input  logic                       sync,
  input  logic [ACC_BITS-1:0]        increment,
  input  logic [PHASE_BITS-1:0]      phase_offset,
  input  logic signed [AMP_BITS-1:0] amplitude,
  output logic signed [OUT_BITS-1:0] out,
  output logic                       out_valid,
  output logic [PHASE_BITS-1:0]      phase_out
);

  localparam int DEPTH = 2 ** PHASE_BITS;
  localparam int K     = 2 ** (OUT_BITS - 1) - 1;
  localparam int PW    = OUT_BITS + AMP_BITS;
  localparam logic [PHASE_BITS-1:0] HALF_TURN = PHASE_BITS'(DEPTH / 2);
  localparam logic [AMP_BITS-1:0]   AMP_MIN   = {1'b1, {(AMP_BITS-1){1'b0}}};
  localparam logic [AMP_BITS-1:0]   AMP_MAX   = {1'b0, {(AMP_BITS-1){1'b1}}};

  // Elaboration-time sine: Taylor series on the angle folded into [-pi, pi],
  // then rounded half away from zero.
  function automatic logic signed [OUT_BITS-1:0] sine_entry(input int idx);
    real pi_val;
    real x;
    real term;
    real sum;
    real v;
    int  r;
    pi_val = 3.14159265358979323846;
    x = 2.0 * pi_val * $itor(idx) / $itor(DEPTH);
    if (x > pi_val) x = x - 2.0 * pi_val;
    term = x;
    sum  = x;
    for (int k = 1; k < 14; k++) begin
      term = -term * x * x / ($itor(2 * k) * $itor(2 * k + 1));
      sum  = sum + term;
    end
    v = $itor(K) * sum;
    if (v >= 0.0) r = $rtoi(v + 0.5);
    else          r = -$rtoi(0.5 - v);
    return OUT_BITS'(r);
  endfunction

  logic signed [OUT_BITS-1:0] lut [DEPTH];

  genvar gi;
  generate
    for (gi = 0; gi < DEPTH; gi++) begin : g_lut
      localparam logic signed [OUT_BITS-1:0] ENTRY = sine_entry(gi);
      assign lut[gi] = ENTRY;
    end
  endgenerate

  logic [ACC_BITS-1:0]        acc_reg;
  logic [PHASE_BITS-1:0]      s1_base_reg;
  logic [PHASE_BITS-1:0]      s1_offset_reg;
  logic signed [AMP_BITS-1:0] s1_amp_reg;
  logic                       s1_valid_reg;
  logic signed [OUT_BITS-1:0] s2_sample_reg;
  logic [AMP_BITS-1:0]        s2_mag_reg;
  logic                       s2_valid_reg;
  logic [PHASE_BITS-1:0]      p_next;
  logic [AMP_BITS-1:0]        mag_next;
  logic signed [PW-1:0]       sample_ext;
  logic signed [PW-1:0]       mag_ext;

  assign phase_out = acc_reg[ACC_BITS-1 -: PHASE_BITS];

  always_ff @(posedge clk) begin
    if (reset)     acc_reg <= '0;
    else if (sync) acc_reg <= '0;
    else if (en)   acc_reg <= acc_reg + increment;
  end

  // A negative amplitude is a half-turn shift of the index with a positive magnitude;
  // the most negative code has no positive twin, so it saturates.
  always_comb begin
    p_next   = s1_base_reg + s1_offset_reg;
    mag_next = s1_amp_reg;
    if (s1_amp_reg[AMP_BITS-1]) begin
      p_next   = p_next + HALF_TURN;
      mag_next = (s1_amp_reg == AMP_MIN) ? AMP_MAX : AMP_BITS'(-s1_amp_reg);
    end
  end

  always_comb begin
    sample_ext = {{AMP_BITS{s2_sample_reg[OUT_BITS-1]}}, s2_sample_reg};
    mag_ext    = {{OUT_BITS{1'b0}}, s2_mag_reg};
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      s1_base_reg   <= '0;
      s1_offset_reg <= '0;
      s1_amp_reg    <= '0;
      s1_valid_reg  <= 1'b0;
      s2_sample_reg <= '0;
      s2_mag_reg    <= '0;
      s2_valid_reg  <= 1'b0;
      out           <= '0;
      out_valid     <= 1'b0;
    end else begin
      s1_base_reg   <= acc_reg[ACC_BITS-1 -: PHASE_BITS];
      s1_offset_reg <= phase_offset;
      s1_amp_reg    <= amplitude;
      s1_valid_reg  <= en;
      s2_sample_reg <= lut[p_next];
      s2_mag_reg    <= mag_next;
      s2_valid_reg  <= s1_valid_reg;
      out           <= OUT_BITS'((sample_ext * mag_ext) >>> (AMP_BITS - 1));
      out_valid     <= s2_valid_reg;
    end
  end

endmodule

// File: doc/sinus_nco.md
SINUS_NCO -- requirements
Module: sinus_nco

Interface
REQ-001 SHALL have parameter ACC_BITS, default 24, phase accumulator width.
REQ-002 SHALL have parameter PHASE_BITS, default 5, sine LUT index width (2^PHASE_BITS entries per turn).
REQ-003 SHALL have parameter AMP_BITS, default 6, signed amplitude width.
REQ-004 SHALL have parameter OUT_BITS, default 8, signed output width.
REQ-005 SHALL have port clk  input  1  single clock; all logic on posedge.
REQ-006 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-007 SHALL have port en  input  1  accumulator advance enable; marks sample valid.
REQ-008 SHALL have port sync  input  1  accumulator reload to zero (e.g. burst start).
REQ-009 SHALL have port increment  input  ACC_BITS  unsigned phase step per enabled cycle.
REQ-010 SHALL have port phase_offset  input  PHASE_BITS  unsigned index offset, one step = 360/2^PHASE_BITS deg.
REQ-011 SHALL have port amplitude  input  AMP_BITS signed  output scale.
REQ-012 SHALL have port out  output  OUT_BITS signed  scaled sine sample.
REQ-013 SHALL have port out_valid  output  1  out carries a sample produced from an enabled cycle.
REQ-014 SHALL have port phase_out  output  PHASE_BITS  acc[ACC_BITS-1 -: PHASE_BITS], registered accumulator top bits.

Function
REQ-015 Accumulator acc SHALL update each clk: sync=1 -> 0; else en=1 -> (acc+increment) mod 2^ACC_BITS; else hold.
REQ-016 sync SHALL take priority over en in the same cycle (acc becomes 0, no increment added).
REQ-017 Stage 1 SHALL register: base index b = acc top PHASE_BITS bits (current register value), phase_offset, amplitude, en.
REQ-018 Index SHALL be p = (b + phase_offset) mod 2^PHASE_BITS; for amplitude<0, p SHALL additionally add 2^(PHASE_BITS-1) mod 2^PHASE_BITS and magnitude m = -amplitude; else m = amplitude.
REQ-019 amplitude = -2^(AMP_BITS-1) SHALL be clamped to m = 2^(AMP_BITS-1)-1 (same as most-negative+1).
REQ-020 Stage 2 SHALL read unit LUT S[p] = round(K*sin(2*pi*p/2^PHASE_BITS)), K = 2^(OUT_BITS-1)-1, rounding half away from zero; LUT content generated at elaboration (no external file), inferable as BRAM/ROM.
REQ-021 Stage 3 SHALL compute out = (S[p]*m) >>> (AMP_BITS-1), arithmetic shift (floor), full-width product of OUT_BITS+AMP_BITS bits, result truncated to OUT_BITS (cannot overflow since m < 2^(AMP_BITS-1)).
REQ-022 Latency SHALL be 3 cycles: out at edge n+3 reflects acc, phase_offset, amplitude as sampled at edge n+1 (register values visible during cycle n).
REQ-023 out_valid SHALL equal en delayed by the same 3 stages; pipeline advances every cycle regardless of en.
REQ-024 With en=0, acc holds so out repeats the held phase's sample and out_valid is 0.
REQ-025 Amplitude/offset changes SHALL take effect on the next sampled cycle with no glitch beyond the 3-cycle pipeline.

Reset
REQ-026 reset=1 at an edge SHALL clear acc, all pipeline registers, out (0), out_valid (0), phase_out (0); reset overrides sync and en.
REQ-027 Reset mid-operation SHALL discard in-flight samples; out_valid SHALL stay 0 until 3 cycles after first en following reset release.

Verification (defaults ACC_BITS=24, PHASE_BITS=5, AMP_BITS=6, OUT_BITS=8; S[4]=90, S[8]=127, S[24]=-127, S[31]=-25)
REQ-028 reset, sync, increment=2^19, amplitude=31, offset=0, en=1 continuous -> index steps 0,1,2..., out at index 0/8/16/24 = 0/123/0/-124; out_valid rises exactly 3 cycles after en.
REQ-029 amplitude=-31 then -32, same stimulus -> index 0 gives 0, index 8 gives -124, index 24 gives 123; -32 output identical to -31.
REQ-030 increment=0xF80000 after sync, amplitude=31 -> index 0,31,30,... out 0,-25,...; acc wraps modulo 2^24 without disturbance.
REQ-031 en=1 with sync=1 same cycle while acc nonzero -> acc=0 next cycle (phase_out=0), no increment; offset=8, amplitude=31 gives out=123 three cycles later.
REQ-032 en toggled 1,0,0,1 -> acc holds during en=0, out_valid mirrors en pattern delayed 3; reset asserted mid-stream -> out=0, out_valid=0 next cycle, and out_valid remains 0 for 3 cycles after re-enable.
